// File: rtl/spi_shifter_if.sv
// spi_shifter_if: bundles the parallel-load, serial and parallel-receive
// signals of the SPI shift engine. The master modport is the parent SPI
// controller; the slave modport is the shift engine itself.
interface spi_shifter_if #(
    parameter int BW = 32
);
    logic [BW-1:0] load_data;
    logic          load_val;
    logic          load_rdy;
    logic          sdi;
    logic          sample_en;
    logic          shift_en;
    logic          sdo;
    logic [BW-1:0] recv_data;
    logic          recv_val;
    logic          recv_rdy;
    logic          busy;

    modport master (
        output load_data,
        output load_val,
        input  load_rdy,
        output sdi,
        output sample_en,
        output shift_en,
        input  sdo,
        input  recv_data,
        input  recv_val,
        output recv_rdy,
        input  busy
    );

    modport slave (
        input  load_data,
        input  load_val,
        output load_rdy,
        input  sdi,
        input  sample_en,
        input  shift_en,
        output sdo,
        output recv_data,
        output recv_val,
        input  recv_rdy,
        output busy
    );
endinterface

// File: rtl/spi_shifter.sv
// spi_shifter: SPI bit-shift engine with a bit counter and valid/ready
// handshakes on the load and receive sides. The parent supplies one-cycle
// sample/shift strobes. A loaded word is launched on sdo while the incoming
// sdi bits are assembled in the same shift register; after BW shifts the
// received word is offered on recv_data until the consumer takes it.
//
// Build option: define SPI_SHIFTER_LSB_FIRST_EN for an LSB-first transfer
// (sdo taken from bit 0, data shifted in at the top). Default is MSB-first.
//
// All outputs are flops loaded from the next-state values, so there is no
// combinational path from any input to any output.
module spi_shifter #(
    parameter  int BW = 32,
    localparam int CW = $clog2(BW + 1)
) (
    input  logic         clk,
    input  logic         reset,
    spi_shifter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_TERM = CW'(BW);

`ifdef SPI_SHIFTER_LSB_FIRST_EN
    localparam int SDO_IDX = 0;
`else
    localparam int SDO_IDX = BW - 1;
`endif

    // Shift one serial bit into the word in the configured direction.
    function automatic logic [BW-1:0] shift_in(input logic [BW-1:0] cur,
                                               input logic          b);
`ifdef SPI_SHIFTER_LSB_FIRST_EN
        return {b, cur[BW-1:1]};
`else
        return {cur[BW-2:0], b};
`endif
    endfunction

    state_t        state_r;
    state_t        state_next_s;
    logic [BW-1:0] shreg_r;
    logic [BW-1:0] shreg_next_s;
    logic          samp_r;
    logic          samp_next_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic [CW-1:0] cnt_inc_s;
    logic          shift_bit_s;

    // Next-state logic: load acceptance, sample/shift handling, terminal count.
    always_comb begin
        state_next_s = state_r;
        shreg_next_s = shreg_r;
        samp_next_s  = samp_r;
        cnt_next_s   = cnt_r;
        cnt_inc_s    = cnt_r + CNT_ONE;

        // A sample strobe coinciding with a shift forwards sdi directly.
        if (bus.sample_en) begin
            shift_bit_s = bus.sdi;
        end else begin
            shift_bit_s = samp_r;
        end

        case (state_r)
            IDLE: begin
                if (bus.load_val) begin
                    shreg_next_s = bus.load_data;
                    cnt_next_s   = {CW{1'b0}};
                    state_next_s = XFER;
                end else begin
                    state_next_s = IDLE;
                end
            end
            XFER: begin
                if (bus.sample_en) begin
                    samp_next_s = bus.sdi;
                end else begin
                    samp_next_s = samp_r;
                end
                if (bus.shift_en) begin
                    shreg_next_s = shift_in(shreg_r, shift_bit_s);
                    cnt_next_s   = cnt_inc_s;
                    if (cnt_inc_s == CNT_TERM) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = XFER;
                    end
                end else begin
                    state_next_s = XFER;
                end
            end
            DONE: begin
                // Word is frozen here; strobes are ignored until handoff.
                if (bus.recv_rdy) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
                shreg_next_s = {BW{1'b0}};
                samp_next_s  = 1'b0;
                cnt_next_s   = {CW{1'b0}};
            end
        endcase
    end

    // Core state: FSM, shift register, captured bit and bit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            shreg_r <= {BW{1'b0}};
            samp_r  <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_next_s;
            shreg_r <= shreg_next_s;
            samp_r  <= samp_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Registered outputs, each equal to the decode of the registered state.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.load_rdy  <= 1'b1;
            bus.busy      <= 1'b0;
            bus.recv_val  <= 1'b0;
            bus.sdo       <= 1'b0;
            bus.recv_data <= {BW{1'b0}};
        end else begin
            bus.load_rdy  <= (state_next_s == IDLE);
            bus.busy      <= (state_next_s == XFER);
            bus.recv_val  <= (state_next_s == DONE);
            bus.sdo       <= shreg_next_s[SDO_IDX];
            bus.recv_data <= shreg_next_s;
        end
    end

endmodule

// File: tb/tb_spi_shifter.sv
// tb_spi_shifter: directed and randomized checks of spi_shifter (BW=8)
// against a transfer-level reference model: the expected word is computed
// from the loaded word and the list of bits shifted in so far.
module tb_spi_shifter;

    localparam int BW = 8;

    logic clk;
    logic reset;

    spi_shifter_if #(.BW(BW)) bus ();

    spi_shifter #(.BW(BW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    // Reference model: phase 0 idle, 1 transferring, 2 word ready.
    int          m_phase;
    logic [63:0] m_load;
    logic        m_samp;
    logic        m_bits[$];

    function automatic logic [BW-1:0] model_word();
        logic [63:0] w;
        int k;
        k = m_bits.size();
`ifdef SPI_SHIFTER_LSB_FIRST_EN
        w = m_load >> k;
        for (int i = 0; i < k; i++) w = w | (64'(m_bits[i]) << (BW - k + i));
`else
        w = m_load << k;
        for (int i = 0; i < k; i++) w = w | (64'(m_bits[i]) << (k - 1 - i));
`endif
        return w[BW-1:0];
    endfunction

    function automatic logic model_sdo();
        logic [BW-1:0] w;
        w = model_word();
`ifdef SPI_SHIFTER_LSB_FIRST_EN
        return w[0];
`else
        return w[BW-1];
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, check all outputs.
    task automatic step(input logic lv, input logic [BW-1:0] ld, input logic sdi_i,
                        input logic se, input logic sh, input logic rr, input logic rst);
        logic b;
        reset         = rst;
        bus.load_val  = lv;
        bus.load_data = ld;
        bus.sdi       = sdi_i;
        bus.sample_en = se;
        bus.shift_en  = sh;
        bus.recv_rdy  = rr;
        if (rst) begin
            m_phase = 0;
            m_load  = 64'd0;
            m_samp  = 1'b0;
            m_bits.delete();
        end else if (m_phase == 0) begin
            if (lv) begin
                m_load  = 64'(ld);
                m_bits.delete();
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            b = se ? sdi_i : m_samp;
            if (se) m_samp = sdi_i;
            if (sh) begin
                m_bits.push_back(b);
                if (m_bits.size() == BW) m_phase = 2;
            end
        end else begin
            if (rr) m_phase = 0;
        end
        @(posedge clk);
        #1;
        check("load_rdy",  64'(bus.load_rdy),  64'(m_phase == 0));
        check("busy",      64'(bus.busy),      64'(m_phase == 1));
        check("recv_val",  64'(bus.recv_val),  64'(m_phase == 2));
        check("sdo",       64'(bus.sdo),       64'(model_sdo()));
        check("recv_data", 64'(bus.recv_data), 64'(model_word()));
    endtask

    // Load a word, then run BW paired strobes with sdo looped back to sdi.
    task automatic loopback(input logic [BW-1:0] w);
        step(1'b1, w, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < BW; i++) step(1'b0, 8'h00, model_sdo(), 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    logic first_sdo_exp;

    initial begin
        tests   = 0;
        fails   = 0;
        m_phase = 0;
        m_load  = 64'd0;
        m_samp  = 1'b0;
        reset         = 1'b1;
        bus.load_val  = 1'b0;
        bus.load_data = 8'h00;
        bus.sdi       = 1'b0;
        bus.sample_en = 1'b0;
        bus.shift_en  = 1'b0;
        bus.recv_rdy  = 1'b0;

        // Reset held for two cycles.
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_load_rdy", 64'(bus.load_rdy), 64'd1);
        check("rst_sdo",      64'(bus.sdo),      64'd0);

        // MSB-first loopback of 0xA5.
        loopback(8'hA5);
        check("loop_a5_val",  64'(bus.recv_val),  64'd1);
        check("loop_a5_data", 64'(bus.recv_data), 64'hA5);

        // Backpressure with stray strobes while the word waits.
        for (int i = 0; i < 5; i++)
            step(1'b1, 8'h5A, 1'(~i[0]), 1'b1, 1'b1, 1'b0, 1'b0);
        check("bp_data",     64'(bus.recv_data), 64'hA5);
        check("bp_load_rdy", 64'(bus.load_rdy),  64'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("bp_release", 64'(bus.load_rdy), 64'd1);

        // Separate strobes: sample 1, shift two cycles later with sdi=0.
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < BW; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        check("sep_data", 64'(bus.recv_data), 64'hFF);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Abort mid-transfer, then a clean transfer of 0x81.
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, model_sdo(), 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("abort_idle",  64'(bus.load_rdy),  64'd1);
        check("abort_shreg", 64'(bus.recv_data), 64'h00);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        loopback(8'h81);
        check("abort_next_data", 64'(bus.recv_data), 64'h81);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // 0x01 loopback: first sdo bit depends on bit order.
`ifdef SPI_SHIFTER_LSB_FIRST_EN
        first_sdo_exp = 1'b1;
`else
        first_sdo_exp = 1'b0;
`endif
        step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("first_sdo", 64'(bus.sdo), 64'(first_sdo_exp));
        for (int i = 0; i < BW; i++) step(1'b0, 8'h00, model_sdo(), 1'b1, 1'b1, 1'b0, 1'b0);
        check("loop_01_data", 64'(bus.recv_data), 64'h01);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(3) == 0), 8'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom_range(2) == 0),
                 1'($urandom_range(79) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
